key_pulse_gen: RTL and testbench

Front-end conditioning stage for the 4-bit down-counter datapath. Takes three raw, bouncing push-button levels (count, set, clear). Synchronises and debounces each one, then emits single-cycle, mutually exclusive command pulses. These pulses drive the counter's `cnt`, `set` and `clear` inputs directly, so one physical press produces exactly one counter action.

---
 rtl/key_pulse_pkg.sv | 20 ++
 rtl/key_debounce.sv | 95 +++++++++
 rtl/key_pulse_gen.sv | 118 +++++++++++
 tb/tb_key_pulse_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/key_pulse_pkg.sv
// Shared types and constants for the key_pulse_gen push-button front end.
package key_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam int CH_CNT = 0;
    localparam int CH_SET = 1;
    localparam int CH_CLR = 2;
    localparam int NUM_CH = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, debounce FSM and saturating stability counter.
module key_debounce
    import key_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic       i_clock,
    input  logic       i_clear,
    input  logic       i_key,
    output deb_state_t o_state,
    output logic       o_press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    deb_state_t    r_state;
    logic [CW-1:0] r_cnt;
    deb_state_t    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_press;

    // Synchroniser, state and counter registers.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state; the sample that leaves a stable state counts as the first of the run.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = {CW{1'b0}};
        w_press     = 1'b0;
        w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_state_nxt = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_state = r_state;
    assign o_press = w_press;

endmodule

// File: rtl/key_pulse_gen.sv
// Three debounced keys arbitrated (clear > set > cnt) into registered one-cycle command pulses.
// Optional cnt auto-repeat is built when KEY_PULSE_AUTO_REPEAT_EN is defined.
module key_pulse_gen
    import key_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 32
)
(
    input  logic       clock,
    input  logic       clear,
    input  logic       key_cnt,
    input  logic       key_set,
    input  logic       key_clear,
    output logic       cnt_pulse,
    output logic       set_pulse,
    output logic       clr_pulse,
    output logic [2:0] pressed
);

    if ((DEBOUNCE_CYCLES < 2) || (REPEAT_PERIOD < 2) || (REPEAT_DELAY < 1)) begin : g_bad_cfg
        $error("key_pulse_gen: unsupported parameter set");
    end

    logic [NUM_CH-1:0] w_keys;
    logic [NUM_CH-1:0] w_press;
    deb_state_t        w_state [NUM_CH];
    logic              w_rep_fire;
    logic              w_cnt_req;
    logic              r_cnt_pulse;
    logic              r_set_pulse;
    logic              r_clr_pulse;

    assign w_keys = {key_clear, key_set, key_cnt};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clock (clock),
            .i_clear (clear),
            .i_key   (w_keys[g]),
            .o_state (w_state[g]),
            .o_press (w_press[g])
        );
    end

`ifdef KEY_PULSE_AUTO_REPEAT_EN
    localparam int            RW        = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_first;
    logic          w_cnt_held;

    // Repeat timer only runs while the cnt key sits in PRESSED.
    always_comb begin
        w_cnt_held = (w_state[CH_CNT] == PRESSED);
        if (w_cnt_held) begin
            w_rep_fire = (r_rep_cnt == (r_rep_first ? REP_FIRST : REP_NEXT));
        end else begin
            w_rep_fire = 1'b0;
        end
    end

    // Repeat counter; restarts on every fire, dropped or not.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_rep_cnt   <= {RW{1'b0}};
            r_rep_first <= 1'b1;
        end else if (!w_cnt_held) begin
            r_rep_cnt   <= {RW{1'b0}};
            r_rep_first <= 1'b1;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= {RW{1'b0}};
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt   <= r_rep_cnt + RW'(1);
            r_rep_first <= r_rep_first;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Priority arbiter request for the cnt channel.
    always_comb begin
        w_cnt_req = w_press[CH_CNT] | w_rep_fire;
    end

    // Registered arbitration; losing events in a cycle are dropped.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_clr_pulse <= 1'b0;
            r_set_pulse <= 1'b0;
            r_cnt_pulse <= 1'b0;
        end else begin
            r_clr_pulse <= w_press[CH_CLR];
            r_set_pulse <= w_press[CH_SET] & ~w_press[CH_CLR];
            r_cnt_pulse <= w_cnt_req & ~w_press[CH_SET] & ~w_press[CH_CLR];
        end
    end

    // Debounced level decode straight from the state registers.
    always_comb begin
        pressed = 3'b000;
        for (int i = 0; i < NUM_CH; i++) begin
            pressed[i] = (w_state[i] == PRESSED) || (w_state[i] == RELEASE_WAIT);
        end
    end

    assign cnt_pulse = r_cnt_pulse;
    assign set_pulse = r_set_pulse;
    assign clr_pulse = r_clr_pulse;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen: directed scenarios plus random bouncing keys vs a run-length model.
module tb_key_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clock = 1'b0;
    logic       clear;
    logic       key_cnt;
    logic       key_set;
    logic       key_clear;
    logic       cnt_pulse;
    logic       set_pulse;
    logic       clr_pulse;
    logic [2:0] pressed;

    always #5 clock = ~clock;

    key_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .key_cnt   (key_cnt),
        .key_set   (key_set),
        .key_clear (key_clear),
        .cnt_pulse (cnt_pulse),
        .set_pulse (set_pulse),
        .clr_pulse (clr_pulse),
        .pressed   (pressed)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: debounced level flips once the last D synchronised samples all disagree with it.
    bit m_s1 [3];
    bit m_s2 [3];
    bit m_run_val [3];
    int m_run_len [3];
    bit m_level [3];
    int m_rep_n;
    bit m_cnt_p, m_set_p, m_clr_p;

    int phase_cyc, seen_cnt, seen_set, seen_clr, first_cnt, first_set, pressed0_cycles;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit raw [3];
        bit evt [3];
        bit held_prev;
        bit fire;
        raw = '{key_cnt, key_set, key_clear};
        fire = 1'b0;
        for (int c = 0; c < 3; c++) evt[c] = 1'b0;
        if (clear) begin
            for (int c = 0; c < 3; c++) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_run_val[c] = 1'b0;
                m_run_len[c] = 0; m_level[c] = 1'b0;
            end
            m_rep_n = 0;
        end else begin
            held_prev = m_level[0] && m_run_val[0];
            for (int c = 0; c < 3; c++) begin
                if (m_s2[c] == m_run_val[c]) begin
                    m_run_len[c]++;
                end else begin
                    m_run_val[c] = m_s2[c];
                    m_run_len[c] = 1;
                end
                if (m_run_len[c] >= D && m_run_val[c] != m_level[c]) begin
                    m_level[c] = m_run_val[c];
                    evt[c] = m_run_val[c];
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
            end
            if (held_prev) begin
                m_rep_n++;
`ifdef KEY_PULSE_AUTO_REPEAT_EN
                fire = (m_rep_n == RD) || (m_rep_n > RD && ((m_rep_n - RD) % RP) == 0);
`endif
            end else begin
                m_rep_n = 0;
            end
        end
        m_clr_p = evt[2];
        m_set_p = evt[1] && !evt[2];
        m_cnt_p = (evt[0] || fire) && !evt[1] && !evt[2];
    endtask

    task automatic cycle(input bit c, input bit k0, input bit k1, input bit k2);
        clear = c; key_cnt = k0; key_set = k1; key_clear = k2;
        @(posedge clock);
        model_step();
        #1;
        phase_cyc++;
        check_val("cnt_pulse", cnt_pulse, m_cnt_p);
        check_val("set_pulse", set_pulse, m_set_p);
        check_val("clr_pulse", clr_pulse, m_clr_p);
        check_val("pressed", pressed, {m_level[2], m_level[1], m_level[0]});
        check_val("one_hot", 32'(cnt_pulse) + 32'(set_pulse) + 32'(clr_pulse) <= 32'd1, 32'd1);
        if (cnt_pulse) begin seen_cnt++; if (first_cnt < 0) first_cnt = phase_cyc; end
        if (set_pulse) begin seen_set++; if (first_set < 0) first_set = phase_cyc; end
        if (clr_pulse) seen_clr++;
        if (pressed[0]) pressed0_cycles++;
    endtask

    task automatic new_phase();
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        phase_cyc = 0; seen_cnt = 0; seen_set = 0; seen_clr = 0;
        first_cnt = -1; first_set = -1; pressed0_cycles = 0;
    endtask

    initial begin
        bit lvl [3];
        int seg [3];
        bit bounce [6];
        clear = 1'b1; key_cnt = 1'b0; key_set = 1'b0; key_clear = 1'b0;
        for (int c = 0; c < 3; c++) begin lvl[c] = 1'b0; seg[c] = 0; end
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("reset_pressed", pressed, 3'd0);
        check_val("reset_pulses", {cnt_pulse, set_pulse, clr_pulse}, 3'd0);

        // Clean press: rise first sampled at edge 1 -> pulse after edge 2+D; level held as long as the key.
        new_phase();
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("clean_first_edge", first_cnt, 2 + D);
`ifdef KEY_PULSE_AUTO_REPEAT_EN
        check_val("clean_cnt_count", seen_cnt, 3);
`else
        check_val("clean_cnt_count", seen_cnt, 1);
`endif
        check_val("clean_pressed_cycles", pressed0_cycles, 20);
        check_val("clean_other_pulses", seen_set + seen_clr, 0);

        // Bounce on set: final stable rise at edge 6 -> pulse after edge 6+1+D.
        new_phase();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, bounce[i], 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("bounce_set_count", seen_set, 1);
        check_val("bounce_set_edge", first_set, 6 + 1 + D);

        // Simultaneous rise: clear wins, others lost.
        new_phase();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("simul_clr_count", seen_clr, 1);
        check_val("simul_set_count", seen_set, 0);
        check_val("simul_cnt_count", seen_cnt, 0);

        // Reset mid-debounce: clear at edges 3,4; edge 5 restarts sampling -> pulse after edge 5+1+D.
        new_phase();
        for (int i = 1; i <= 20; i++) cycle((i == 3) || (i == 4), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst_first_edge", first_cnt, 5 + 1 + D);
`ifdef KEY_PULSE_AUTO_REPEAT_EN
        check_val("rst_cnt_count", seen_cnt, 2);
`else
        check_val("rst_cnt_count", seen_cnt, 1);
`endif

        // Random bouncing keys with occasional resets.
        new_phase();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (seg[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    seg[c] = $urandom_range(1, 14);
                end
                seg[c]--;
            end
            cycle(($urandom_range(0, 299) == 0), lvl[0], lvl[1], lvl[2]);
        end
        check_val("random_saw_presses", (seen_cnt > 0) && (seen_set > 0) && (seen_clr > 0), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
